// File: rtl/ccip_vec_add_engine.sv
// Streaming lane-wise vector adder AFU core on flat CCI-P ports.
// Reads src lines (A|B), writes A+B result lines to dst, with CSRs.
module ccip_vec_add_engine #(
   parameter int           OPERAND_W       = 32,
   parameter int           MAX_OUTSTANDING = 8,
   parameter logic [127:0] AFU_ID          = 128'h0
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         mmio_wr_valid,
   input  logic         mmio_rd_valid,
   input  logic [15:0]  mmio_addr,
   input  logic [8:0]   mmio_tid,
   input  logic [63:0]  mmio_wdata,
   output logic         mmio_rsp_valid,
   output logic [8:0]   mmio_rsp_tid,
   output logic [63:0]  mmio_rsp_data,
   input  logic         c0_almfull,
   output logic         c0_req_valid,
   output logic [41:0]  c0_req_addr,
   output logic [15:0]  c0_req_mdata,
   input  logic         c0_rsp_valid,
   input  logic [15:0]  c0_rsp_mdata,
   input  logic [511:0] c0_rsp_data,
   input  logic         c1_almfull,
   output logic         c1_req_valid,
   output logic [41:0]  c1_req_addr,
   output logic [15:0]  c1_req_mdata,
   output logic [511:0] c1_req_data,
   input  logic         c1_rsp_valid
);
   localparam int LANES = 256 / OPERAND_W;
   localparam int SW    = $clog2(MAX_OUTSTANDING);
   localparam int PW    = $clog2(LANES + 1);
   localparam logic [SW:0] MAXS = (SW+1)'(MAX_OUTSTANDING);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]  state;
   logic [41:0] src, dst;
   logic [15:0] num_lines, issued, lines_done;
   logic [63:0] ovf_count;
   logic        sat, done, active, start, issue_rd;
   logic [SW:0] slots;

   logic           st_valid;
   logic [255:0]   st_res;
   logic [15:0]    st_tag;
   logic [PW-1:0]  st_pop, pop;
   logic [LANES-1:0] carry;
   logic [255:0]   lane_sum;

   logic [255:0] fifo_res [MAX_OUTSTANDING];
   logic [15:0]  fifo_tag [MAX_OUTSTANDING];
   logic [SW:0]  wp, rp;
   logic         empty, full;
   logic [63:0]  rd_data;
   logic [64:0]  ovf_sum;
   logic         unused_bits;

   assign unused_bits = ^mmio_wdata[63:42];
   assign active = (state == S_RUN) || (state == S_DRAIN);
   assign start  = mmio_wr_valid && (mmio_addr == 16'h16) &&
                   (state == S_IDLE) && mmio_wdata[0];
   assign issue_rd = (state == S_RUN) && (issued < num_lines) &&
                     !c0_almfull && (slots < MAXS);

   assign c0_req_valid = issue_rd;
   assign c0_req_addr  = issue_rd ? src + 42'(issued) : '0;
   assign c0_req_mdata = issue_rd ? issued : '0;

   assign empty = (wp == rp);
   assign full  = (wp[SW] != rp[SW]) && (wp[SW-1:0] == rp[SW-1:0]);

   assign c1_req_valid = !empty && !c1_almfull;
   assign c1_req_mdata = c1_req_valid ? fifo_tag[rp[SW-1:0]] : '0;
   assign c1_req_addr  = c1_req_valid ? dst + 42'(c1_req_mdata) : '0;
   assign c1_req_data  = c1_req_valid ?
                         {256'b0, fifo_res[rp[SW-1:0]]} : '0;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [OPERAND_W:0] s;
      assign s = {1'b0, c0_rsp_data[i*OPERAND_W +: OPERAND_W]} +
                 {1'b0, c0_rsp_data[256 + i*OPERAND_W +: OPERAND_W]};
      assign carry[i] = s[OPERAND_W];
      assign lane_sum[i*OPERAND_W +: OPERAND_W] =
         (sat && carry[i]) ? {OPERAND_W{1'b1}} : s[OPERAND_W-1:0];
   end

   always_comb begin
      pop = '0;
      for (int i = 0; i < LANES; i++) pop = pop + PW'(carry[i]);
   end

   assign ovf_sum = {1'b0, ovf_count} + 65'(st_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_valid <= 1'b0;
         st_res   <= '0;
         st_tag   <= '0;
         st_pop   <= '0;
      end else begin
         st_valid <= c0_rsp_valid && active;
         st_res   <= lane_sum;
         st_tag   <= c0_rsp_mdata;
         st_pop   <= pop;
      end
   end

   always_ff @(posedge clk) begin
      if (st_valid) begin
         fifo_res[wp[SW-1:0]] <= st_res;
         fifo_tag[wp[SW-1:0]] <= st_tag;
      end
   end

   // Slot accounting makes a push to a full FIFO impossible.
   always_ff @(posedge clk) begin
      if (reset_n && st_valid) assert (!full);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wp    <= '0;
         rp    <= '0;
         slots <= '0;
      end else begin
         if (st_valid) wp <= wp + 1'b1;
         if (c1_req_valid) rp <= rp + 1'b1;
         if (issue_rd && !c1_req_valid) slots <= slots + 1'b1;
         else if (!issue_rd && c1_req_valid) slots <= slots - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         src       <= '0;
         dst       <= '0;
         num_lines <= '0;
      end else if (mmio_wr_valid && state == S_IDLE) begin
         if (mmio_addr == 16'h10) src <= mmio_wdata[41:0];
         if (mmio_addr == 16'h12) dst <= mmio_wdata[41:0];
         if (mmio_addr == 16'h14) num_lines <= mmio_wdata[15:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         sat        <= 1'b0;
         done       <= 1'b0;
         issued     <= '0;
         lines_done <= '0;
         ovf_count  <= '0;
      end else begin
         if (issue_rd) issued <= issued + 1'b1;
         if (c1_rsp_valid && active) lines_done <= lines_done + 1'b1;
         if (st_valid) ovf_count <= ovf_sum[64] ? '1 : ovf_sum[63:0];
         case (state)
            S_IDLE: if (start) begin
               sat        <= mmio_wdata[1];
               done       <= 1'b0;
               issued     <= '0;
               lines_done <= '0;
               ovf_count  <= '0;
               state      <= (num_lines == 16'd0) ? S_DONE : S_RUN;
            end
            S_RUN:   if (issued == num_lines) state <= S_DRAIN;
            S_DRAIN: if (lines_done == num_lines) state <= S_DONE;
            default: begin
               done  <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      case (mmio_addr)
         16'h00:  rd_data = 64'h1000_0100_0000_0000;
         16'h02:  rd_data = AFU_ID[63:0];
         16'h04:  rd_data = AFU_ID[127:64];
         16'h18:  rd_data = {62'b0, done, state != S_IDLE};
         16'h1A:  rd_data = {48'b0, lines_done};
         16'h1C:  rd_data = ovf_count;
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mmio_rsp_valid <= 1'b0;
         mmio_rsp_tid   <= '0;
         mmio_rsp_data  <= '0;
      end else begin
         mmio_rsp_valid <= mmio_rd_valid;
         mmio_rsp_tid   <= mmio_rd_valid ? mmio_tid : '0;
         mmio_rsp_data  <= mmio_rd_valid ? rd_data : '0;
      end
   end
endmodule
